// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: S-box geometry and PRGA controller states.
// Imported by the message decryptor.
package rc4_pkg;

  localparam int S_WIDTH = 8;
  localparam int S_DEPTH = 256;

  typedef logic [S_WIDTH-1:0] sbyte_t;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    RD_SI  = 4'd1,
    WT_SI  = 4'd2,
    RD_SJ  = 4'd3,
    WT_SJ  = 4'd4,
    WR_SI  = 4'd5,
    WR_SJ  = 4'd6,
    RD_F   = 4'd7,
    WT_F   = 4'd8,
    WR_MSG = 4'd9,
    DONE   = 4'd10
  } state_e;

  function automatic logic f_busy(input state_e s);
    return !((s == IDLE) || (s == DONE));
  endfunction

endpackage

// File: rtl/msg_decryptor.sv
// RC4 PRGA message decryptor over an externally held, pre-keyed S-box.
// Nine cycles per byte: two-cycle reads, two swap writes, one output write.
module msg_decryptor
  import rc4_pkg::*;
#(
  parameter int MSG_LEN        = 32,
  parameter int MSG_ADDR_WIDTH = 5
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      start,
  output logic [S_WIDTH-1:0]        s_address,
  output logic [S_WIDTH-1:0]        s_data,
  output logic                      s_wren,
  input  logic [S_WIDTH-1:0]        s_q,
  output logic [MSG_ADDR_WIDTH-1:0] rom_address,
  input  logic [7:0]                rom_q,
  output logic [7:0]                msg_address,
  output logic [7:0]                msg_data,
  output logic                      msg_wren,
  output logic                      busy,
  output logic                      done
);

  localparam logic [MSG_ADDR_WIDTH-1:0] K_LAST =
    MSG_ADDR_WIDTH'(MSG_LEN - 1);
  localparam logic [MSG_ADDR_WIDTH-1:0] K_ONE =
    MSG_ADDR_WIDTH'(1);

  state_e              r_state;
  state_e              w_next;
  sbyte_t              r_i;
  sbyte_t              r_j;
  sbyte_t              r_si;
  sbyte_t              r_sj;
  logic [MSG_ADDR_WIDTH-1:0] r_k;
  logic [7:0]          r_msg;
  logic                w_last;
  logic                w_go;

  assign w_last = (r_k == K_LAST);
  assign w_go   = start && !f_busy(r_state);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_go) w_next = RD_SI;
      DONE:    if (w_go) w_next = RD_SI;
      RD_SI:   w_next = WT_SI;
      WT_SI:   w_next = RD_SJ;
      RD_SJ:   w_next = WT_SJ;
      WT_SJ:   w_next = WR_SI;
      WR_SI:   w_next = WR_SJ;
      WR_SJ:   w_next = RD_F;
      RD_F:    w_next = WT_F;
      WT_F:    w_next = WR_MSG;
      WR_MSG:  w_next = w_last ? DONE : RD_SI;
      default: w_next = IDLE;
    endcase
  end

  // Datapath registers advance only at the end of their owning state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_i   <= '0;
      r_j   <= '0;
      r_k   <= '0;
      r_si  <= '0;
      r_sj  <= '0;
      r_msg <= '0;
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          if (w_go) begin
            r_i <= 8'd1;
            r_j <= '0;
            r_k <= '0;
          end
        end
        WT_SI: begin
          r_si <= s_q;
          r_j  <= r_j + s_q;
        end
        WT_SJ: begin
          r_sj <= s_q;
        end
        WT_F: begin
          r_msg <= s_q ^ rom_q;
        end
        WR_MSG: begin
          if (!w_last) begin
            r_k <= r_k + K_ONE;
            r_i <= r_i + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    s_address   = '0;
    s_data      = '0;
    s_wren      = 1'b0;
    rom_address = '0;
    msg_address = '0;
    msg_wren    = 1'b0;
    unique case (r_state)
      RD_SI: s_address = r_i;
      RD_SJ: s_address = r_j;
      WR_SI: begin
        s_address = r_i;
        s_data    = r_sj;
        s_wren    = 1'b1;
      end
      WR_SJ: begin
        s_address = r_j;
        s_data    = r_si;
        s_wren    = 1'b1;
      end
      RD_F: begin
        s_address   = r_si + r_sj;
        rom_address = r_k;
      end
      WR_MSG: begin
        msg_address = 8'(r_k);
        msg_wren    = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign msg_data = r_msg;
  assign busy     = f_busy(r_state);
  assign done     = (r_state == DONE);

endmodule
